alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 55 +++++
 rtl/alu_seq_decode.sv | 33 +++
 rtl/alu_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, flag bit
// indices and instruction field positions.
// Optional build macro: ALU_SEQ_MULDIV_STALL_EN (adds the STALL state).
package alu_seq_pkg;

    localparam int OPC_W   = 5;
    localparam int NUM_OPS = 19;

    localparam logic [OPC_W-1:0] OP_NOP = 5'd0;
    localparam logic [OPC_W-1:0] OP_ADD = 5'd1;
    localparam logic [OPC_W-1:0] OP_SUB = 5'd2;
    localparam logic [OPC_W-1:0] OP_ADC = 5'd3;
    localparam logic [OPC_W-1:0] OP_SBB = 5'd4;
    localparam logic [OPC_W-1:0] OP_MUL = 5'd5;
    localparam logic [OPC_W-1:0] OP_DIV = 5'd6;
    localparam logic [OPC_W-1:0] OP_INC = 5'd7;
    localparam logic [OPC_W-1:0] OP_DEC = 5'd8;
    localparam logic [OPC_W-1:0] OP_SHL = 5'd9;
    localparam logic [OPC_W-1:0] OP_SHR = 5'd10;
    localparam logic [OPC_W-1:0] OP_NOT = 5'd11;
    localparam logic [OPC_W-1:0] OP_NEG = 5'd12;
    localparam logic [OPC_W-1:0] OP_AND = 5'd13;
    localparam logic [OPC_W-1:0] OP_OR  = 5'd14;
    localparam logic [OPC_W-1:0] OP_JMP = 5'd15;
    localparam logic [OPC_W-1:0] OP_JA  = 5'd16;
    localparam logic [OPC_W-1:0] OP_JB  = 5'd17;
    localparam logic [OPC_W-1:0] OP_JE  = 5'd18;

    // Architectural flag bit positions
    localparam int FLAG_CF = 0;
    localparam int FLAG_PF = 1;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_SF = 3;
    localparam int FLAG_OF = 4;

    // Instruction field positions
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 11;
    localparam int TGT1_MSB = 10;
    localparam int TGT1_LSB = 7;
    localparam int TGT2_MSB = 6;
    localparam int TGT2_LSB = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3
`ifdef ALU_SEQ_MULDIV_STALL_EN
        ,
        ST_STALL  = 3'd4
`endif
    } state_e;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder: one-hot strobe vector plus class flags.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode,
    output logic [NUM_OPS-1:0] onehot,
    output logic               legal,
    output logic               is_wb,
    output logic               is_r1,
    output logic               is_jump,
    output logic               is_flag
);

    // Bit 0 (NOP) never strobes the ALU
    assign onehot[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_OPS; gi = gi + 1) begin : g_onehot
            assign onehot[gi] = (opcode == OPC_W'(gi));
        end
    endgenerate

    // Opcode class decode
    always_comb begin
        legal   = (opcode < OPC_W'(NUM_OPS));
        is_wb   = (opcode >= OP_ADD) && (opcode <= OP_OR);
        is_r1   = (opcode == OP_MUL) || (opcode == OP_DIV);
        is_jump = (opcode >= OP_JMP) && (opcode <= OP_JE);
        is_flag = is_wb;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Four-phase ALU instruction sequencer: IDLE -> DECODE -> EXEC -> WB.
// Optional build macro: ALU_SEQ_MULDIV_STALL_EN adds a STALL phase after EXEC
// for MUL/DIV lasting MULDIV_STALL cycles.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MULDIV_STALL = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [15:0]         instr,
    output logic [NUM_OPS-1:0]  op_stb,
    output logic [3:0]          tgt1,
    output logic [3:0]          tgt2,
    output logic                ealu,
    output logic [7:0]          flags_in,
    input  logic [7:0]          alu_flags,
    input  logic                alu_ij,
    input  logic [7:0]          alu_dout,
    input  logic [7:0]          alu_dout_r1,
    output logic                wb_en,
    output logic                wb_r1_en,
    output logic [7:0]          wb_data,
    output logic [7:0]          wb_r1_data,
    output logic                pc_load,
    output logic [7:0]          pc_target,
    output logic                done,
    output logic                illegal
);

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic [3:0]       tgt1_q, tgt1_d, tgt2_q, tgt2_d;
    logic [7:0]       dout_q, dout_d, dout_r1_q, dout_r1_d;
    logic [4:0]       aflags_q, aflags_d;
    logic             ij_q, ij_d;
    logic [4:0]       flags_q, flags_d;
    logic             illegal_q, illegal_d;
    logic             capture;

    logic [NUM_OPS-1:0] dec_onehot;
    logic dec_legal, dec_is_wb, dec_is_r1, dec_is_jump, dec_is_flag;

    // Reserved instruction bits and the upper ALU flag bits carry no state
    logic unused_bits;
    assign unused_bits = ^{instr[2:0], alu_flags[7:5]};

    // The stall depth only affects the stall build; the range 1..7 fits the 3-bit counter
    generate
        if (MULDIV_STALL < 1 || MULDIV_STALL > 7) begin : g_stall_out_of_range
        end
    endgenerate

    alu_seq_decode u_decode (
        .opcode  (opc_q),
        .onehot  (dec_onehot),
        .legal   (dec_legal),
        .is_wb   (dec_is_wb),
        .is_r1   (dec_is_r1),
        .is_jump (dec_is_jump),
        .is_flag (dec_is_flag)
    );

`ifdef ALU_SEQ_MULDIV_STALL_EN
    logic [2:0] stall_cnt_q, stall_cnt_d;
`endif

    // Next-state logic; capture marks the cycle whose end latches ALU results
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        illegal_d = 1'b0;
`ifdef ALU_SEQ_MULDIV_STALL_EN
        stall_cnt_d = stall_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d   = ST_IDLE;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
`ifdef ALU_SEQ_MULDIV_STALL_EN
                if (dec_is_r1) begin
                    state_d     = ST_STALL;
                    stall_cnt_d = 3'd0;
                end else begin
                    state_d = ST_WB;
                    capture = 1'b1;
                end
`else
                state_d = ST_WB;
                capture = 1'b1;
`endif
            end
`ifdef ALU_SEQ_MULDIV_STALL_EN
            ST_STALL: begin
                if (stall_cnt_q == 3'(MULDIV_STALL - 1)) begin
                    state_d = ST_WB;
                    capture = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + 3'd1;
                end
            end
`endif
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: instruction latch, ALU result capture, flag update
    always_comb begin
        opc_d     = opc_q;
        tgt1_d    = tgt1_q;
        tgt2_d    = tgt2_q;
        dout_d    = dout_q;
        dout_r1_d = dout_r1_q;
        aflags_d  = aflags_q;
        ij_d      = ij_q;
        flags_d   = flags_q;
        if (state_q == ST_IDLE && instr_valid) begin
            opc_d  = instr[OPC_MSB:OPC_LSB];
            tgt1_d = instr[TGT1_MSB:TGT1_LSB];
            tgt2_d = instr[TGT2_MSB:TGT2_LSB];
        end
        if (capture) begin
            dout_d    = alu_dout;
            dout_r1_d = alu_dout_r1;
            aflags_d  = alu_flags[FLAG_OF:FLAG_CF];
            ij_d      = alu_ij;
        end
        if (state_q == ST_WB && dec_is_flag) begin
            flags_d = aflags_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            opc_q     <= '0;
            tgt1_q    <= '0;
            tgt2_q    <= '0;
            dout_q    <= '0;
            dout_r1_q <= '0;
            aflags_q  <= '0;
            ij_q      <= 1'b0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            tgt1_q    <= tgt1_d;
            tgt2_q    <= tgt2_d;
            dout_q    <= dout_d;
            dout_r1_q <= dout_r1_d;
            aflags_q  <= aflags_d;
            ij_q      <= ij_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef ALU_SEQ_MULDIV_STALL_EN
    // Stall cycle counter
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= 3'd0;
        else     stall_cnt_q <= stall_cnt_d;
    end
`endif

    // Output decode; everything not asserted is driven to zero
    always_comb begin
        instr_ready = (state_q == ST_IDLE) && !rst;
        op_stb      = '0;
        ealu        = 1'b0;
        wb_en       = 1'b0;
        wb_r1_en    = 1'b0;
        wb_data     = 8'h00;
        wb_r1_data  = 8'h00;
        pc_load     = 1'b0;
        pc_target   = 8'h00;
        done        = 1'b0;
        illegal     = illegal_q;
        tgt1        = tgt1_q;
        tgt2        = tgt2_q;
        flags_in    = {3'b000, flags_q};
        case (state_q)
            ST_EXEC: begin
                op_stb = dec_onehot;
                ealu   = 1'b1;
            end
`ifdef ALU_SEQ_MULDIV_STALL_EN
            ST_STALL: begin
                op_stb = dec_onehot;
                ealu   = 1'b1;
            end
`endif
            ST_WB: begin
                done = 1'b1;
                if (dec_is_wb) begin
                    wb_en   = 1'b1;
                    wb_data = dout_q;
                end
                if (dec_is_r1) begin
                    wb_r1_en   = 1'b1;
                    wb_r1_data = dout_r1_q;
                end
                if (dec_is_jump && ij_q) begin
                    pc_load   = 1'b1;
                    pc_target = dout_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
